// File: rtl/rr_first_valid.sv
// Combinational find-first-set over a valid vector, scanning upward from a
// rotating pointer with wrap at NumInp-1 -> 0.
module rr_first_valid #(
   parameter int unsigned NumInp = 4,
   localparam int unsigned IdxW = $clog2(NumInp)
) (
   input  logic [NumInp-1:0] valid_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [IdxW-1:0]   idx_o,
   output logic              found_o
);

   logic [IdxW:0] pos;

   always_comb begin
      idx_o   = ptr_i;
      found_o = 1'b0;
      pos     = '0;
      for (int unsigned k = 0; k < NumInp; k++) begin
         // one extra bit so the sum cannot overflow before the wrap
         pos = {1'b0, ptr_i} + (IdxW+1)'(k);
         if (pos >= (IdxW+1)'(NumInp)) pos = pos - (IdxW+1)'(NumInp);
         if (!found_o && valid_i[pos[IdxW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = pos[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/time_lock_rr_arb.sv
// Lockable round-robin arbiter in front of the time-redundancy start stage;
// keeps redundant copies adjacent and releases idle locks via a watchdog.
module time_lock_rr_arb #(
   parameter int unsigned NumInp      = 4,
   parameter type         DataType    = logic,
   parameter int unsigned LockTimeout = 4,
   localparam int unsigned IdxW = $clog2(NumInp)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  DataType [NumInp-1:0]   inp_data_i,
   input  logic    [NumInp-1:0]   inp_valid_i,
   output logic    [NumInp-1:0]   inp_ready_o,
   output DataType                oup_data_o,
   output logic                   oup_valid_o,
   input  logic                   oup_ready_i,
   output logic    [IdxW-1:0]     idx_o,
   input  logic                   lock_i,
   output logic                   timeout_o
);

   localparam int unsigned CntW = $clog2(LockTimeout+1);

   logic [IdxW-1:0] prio_q, prio_d;
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic            hold_q, hold_d;
   logic [IdxW-1:0] hold_idx_q, hold_idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [IdxW-1:0] rr_idx, winner, win_inc;
   logic            any_valid, hs, idle, fire;

   rr_first_valid #(.NumInp(NumInp)) i_first (
      .valid_i (inp_valid_i),
      .ptr_i   (prio_q),
      .idx_o   (rr_idx),
      .found_o (any_valid)
   );

   always_comb begin
      winner = lock_q ? lock_idx_q : (hold_q ? hold_idx_q : rr_idx);
      win_inc = (winner == IdxW'(NumInp-1)) ? '0 : winner + 1'b1;

      oup_valid_o = any_valid & inp_valid_i[winner];
      oup_data_o  = inp_data_i[winner];
      idx_o       = any_valid ? winner : prio_q;
      inp_ready_o = '0;
      if (any_valid) inp_ready_o[winner] = oup_ready_i;

      hs        = oup_valid_o & oup_ready_i;
      idle      = !inp_valid_i[lock_idx_q];
      fire      = enable_i & lock_q & idle & (cnt_q == CntW'(LockTimeout-1));
      timeout_o = fire;
   end

   // next-state for the whole control register set
   always_comb begin
      prio_d     = prio_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      hold_d     = hold_q;
      hold_idx_d = hold_idx_q;
      cnt_d      = cnt_q;

      if (hs) prio_d = win_inc;

      if (!enable_i) begin
         lock_d = 1'b0;
         hold_d = 1'b0;
         cnt_d  = '0;
      end else begin
         // a stalled valid pins the grant until it handshakes
         if (hs) begin
            hold_d = 1'b0;
         end else if (oup_valid_o && !lock_q) begin
            hold_d     = 1'b1;
            hold_idx_d = winner;
         end

         if (!lock_q) begin
            if (hs && lock_i) begin
               lock_d     = 1'b1;
               lock_idx_d = winner;
               cnt_d      = '0;
            end
         end else if (fire || !lock_i) begin
            lock_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d = idle ? cnt_q + 1'b1 : '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         prio_q     <= prio_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_time_lock_rr_arb.sv
// Directed plus randomized bench for time_lock_rr_arb against a cycle-level
// reference model of the arbitration, lock and watchdog rules.
module tb_time_lock_rr_arb;

   localparam int N  = 4;
   localparam int LT = 4;
   typedef logic [7:0] data_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   data_t [N-1:0] inp_data;
   logic [N-1:0]  inp_valid;
   logic [N-1:0]  inp_ready;
   data_t         oup_data;
   logic          oup_valid;
   logic          oup_ready;
   logic [1:0]    idx;
   logic          lock;
   logic          timeout;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int m_prio, m_lock_idx, m_hold_idx, m_idle;
   bit m_lock, m_hold;

   always #5 clk = ~clk;

   time_lock_rr_arb #(.NumInp(N), .DataType(data_t), .LockTimeout(LT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .inp_data_i  (inp_data),
      .inp_valid_i (inp_valid),
      .inp_ready_o (inp_ready),
      .oup_data_o  (oup_data),
      .oup_valid_o (oup_valid),
      .oup_ready_i (oup_ready),
      .idx_o       (idx),
      .lock_i      (lock),
      .timeout_o   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prio = 0; m_lock = 0; m_lock_idx = 0; m_hold = 0; m_hold_idx = 0; m_idle = 0;
   endtask

   // One cycle: settle, check against model (and optional directed values),
   // clock, then advance the model with the inputs that were applied.
   task automatic tick(input int exp_idx, input int exp_to);
      int w;
      bit any, ev, fire, hs;
      logic [N-1:0] er;
      #1;
      if (exp_idx >= 0) chk("dir_idx", 32'(idx), 32'(exp_idx));
      if (exp_to >= 0)  chk("dir_timeout", 32'(timeout), 32'(exp_to));

      any = (inp_valid != 0);
      if (m_lock) w = m_lock_idx;
      else if (m_hold) w = m_hold_idx;
      else begin
         w = m_prio;
         for (int k = N-1; k >= 0; k--)
            if (inp_valid[(m_prio + k) % N]) w = (m_prio + k) % N;
      end
      ev   = any && inp_valid[w];
      er   = (any && oup_ready) ? N'(1) << w : '0;
      fire = enable && m_lock && !inp_valid[m_lock_idx] && (m_idle == LT-1);
      hs   = ev && oup_ready;

      chk("valid", 32'(oup_valid), 32'(ev));
      chk("idx", 32'(idx), any ? 32'(w) : 32'(m_prio));
      chk("ready", 32'(inp_ready), 32'(er));
      chk("timeout", 32'(timeout), 32'(fire));
      if (ev) chk("data", 32'(oup_data), 32'(inp_data[w]));

      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (hs) m_prio = (w + 1) % N;
         if (!enable) begin
            m_lock = 0; m_hold = 0; m_idle = 0;
         end else begin
            if (hs) m_hold = 0;
            else if (ev && !m_lock) begin m_hold = 1; m_hold_idx = w; end
            if (!m_lock) begin
               if (hs && lock) begin m_lock = 1; m_lock_idx = w; m_idle = 0; end
            end else if (fire || !lock) begin
               m_lock = 0; m_idle = 0;
            end else begin
               m_idle = inp_valid[m_lock_idx] ? 0 : m_idle + 1;
            end
         end
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; inp_valid = '0; oup_ready = 1'b0; lock = 1'b0;
      for (int i = 0; i < N; i++) inp_data[i] = data_t'(8'h10 + i);
      model_reset();

      // reset state
      tick(0, 0);
      rst = 1'b0;

      // plain round robin between 0 and 2
      inp_valid = 4'b0101; oup_ready = 1'b1;
      tick(0, 0); tick(2, 0); tick(0, 0); tick(2, 0);

      // stall on 1, grant must not move when 0 arrives
      inp_valid = 4'b0010; oup_ready = 1'b0;
      tick(1, 0);
      inp_valid = 4'b0011;
      tick(1, 0); tick(1, 0);
      oup_ready = 1'b1;
      tick(1, 0);
      inp_valid = 4'b0001;
      tick(0, 0);

      // lock on 3 while everyone requests
      inp_valid = 4'b1000; lock = 1'b1;
      tick(3, 0);
      inp_valid = 4'b1111;
      tick(3, 0); tick(3, 0); tick(3, 0);
      lock = 1'b0;
      tick(3, 0);
      tick(0, 0);

      // lock on 2 then let it go idle until the watchdog fires
      inp_valid = 4'b0100; lock = 1'b1;
      tick(2, 0);
      inp_valid = 4'b1011;
      tick(2, 0); tick(2, 0); tick(2, 0); tick(2, 1);
      lock = 1'b0;
      tick(3, 0);

      // lock on 1 with alternating valid: watchdog never fires
      inp_valid = 4'b0010; lock = 1'b1;
      tick(1, 0);
      for (int i = 0; i < 10; i++) begin
         inp_valid = (i % 2 == 0) ? 4'b1101 : 4'b0010;
         tick(1, 0);
      end

      // disabled: lock request ignored
      enable = 1'b0; inp_valid = 4'b1111;
      tick(1, 0); tick(2, 0); tick(3, 0); tick(0, 0);

      // reset while locked
      enable = 1'b1;
      tick(1, 0); tick(1, 0);
      rst = 1'b1; model_reset();
      tick(0, 0);
      rst = 1'b0; lock = 1'b0;

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         inp_valid = N'($urandom);
         oup_ready = ($urandom_range(0, 3) != 0);
         lock      = ($urandom_range(0, 9) < 7);
         enable    = ($urandom_range(0, 19) != 0);
         for (int j = 0; j < N; j++) inp_data[j] = data_t'($urandom);
         tick(-1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
